// File: rtl/fft_pkg.sv
// Constants and complex-word helpers shared by all stages of the 16-point FFT.
// Twiddles are W_k = exp(-j*2*pi*k/16) in Q16.16, rounded to nearest.
package fft_pkg;

  localparam int N_POINT = 16;
  localparam int CPLX_W  = 64;
  localparam int PART_W  = 32;
  localparam int FRAC_Q  = 16;

  localparam logic [PART_W-1:0] W0_RE = 32'h0001_0000;
  localparam logic [PART_W-1:0] W0_IM = 32'h0000_0000;
  localparam logic [PART_W-1:0] W1_RE = 32'h0000_EC83;
  localparam logic [PART_W-1:0] W1_IM = 32'hFFFF_9E08;
  localparam logic [PART_W-1:0] W2_RE = 32'h0000_B505;
  localparam logic [PART_W-1:0] W2_IM = 32'hFFFF_4AFB;
  localparam logic [PART_W-1:0] W3_RE = 32'h0000_61F8;
  localparam logic [PART_W-1:0] W3_IM = 32'hFFFF_137D;
  localparam logic [PART_W-1:0] W4_RE = 32'h0000_0000;
  localparam logic [PART_W-1:0] W4_IM = 32'hFFFF_0000;
  localparam logic [PART_W-1:0] W5_RE = 32'hFFFF_9E08;
  localparam logic [PART_W-1:0] W5_IM = 32'hFFFF_137D;
  localparam logic [PART_W-1:0] W6_RE = 32'hFFFF_4AFB;
  localparam logic [PART_W-1:0] W6_IM = 32'hFFFF_4AFB;
  localparam logic [PART_W-1:0] W7_RE = 32'hFFFF_137D;
  localparam logic [PART_W-1:0] W7_IM = 32'hFFFF_9E08;

  typedef logic [CPLX_W-1:0] cplx_t;

  function automatic cplx_t make_cplx(input logic [PART_W-1:0] re, input logic [PART_W-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_s2p_buffer.sv
// Serial-to-parallel front end of the FFT: gathers 16 Q8.8 samples into a fill
// bank and publishes a whole Q16.16 complex frame at once with a one-cycle strobe.
module fft_s2p_buffer
  import fft_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int PAD_LSB = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fir_valid,
  input  logic [IN_W-1:0]   fir_d,
  output logic [CPLX_W-1:0] fft_data0_out,
  output logic [CPLX_W-1:0] fft_data1_out,
  output logic [CPLX_W-1:0] fft_data2_out,
  output logic [CPLX_W-1:0] fft_data3_out,
  output logic [CPLX_W-1:0] fft_data4_out,
  output logic [CPLX_W-1:0] fft_data5_out,
  output logic [CPLX_W-1:0] fft_data6_out,
  output logic [CPLX_W-1:0] fft_data7_out,
  output logic [CPLX_W-1:0] fft_data8_out,
  output logic [CPLX_W-1:0] fft_data9_out,
  output logic [CPLX_W-1:0] fft_data10_out,
  output logic [CPLX_W-1:0] fft_data11_out,
  output logic [CPLX_W-1:0] fft_data12_out,
  output logic [CPLX_W-1:0] fft_data13_out,
  output logic [CPLX_W-1:0] fft_data14_out,
  output logic [CPLX_W-1:0] fft_data15_out,
  output logic              fft_valid,
  output logic [3:0]        frame_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(N_POINT - 1);

  logic [PART_W-1:0] sample_re_s;
  cplx_t             sample_cplx_s;
  logic [3:0]        wr_idx_r;
  logic [3:0]        frame_cnt_r;
  logic              fft_valid_r;
  cplx_t             fill_bank_r [N_POINT];
  cplx_t             out_bank_r  [N_POINT];

  // Q8.8 -> Q16.16: sign-extend above, pad zeros below, nothing else.
  assign sample_re_s = {{(PART_W-IN_W-PAD_LSB){fir_d[IN_W-1]}}, fir_d, {PAD_LSB{1'b0}}};

  // Pack the formatted real part with a zero imaginary part.
  always_comb begin
    sample_cplx_s = make_cplx(sample_re_s, 32'h0000_0000);
  end

  // Fill bank, output bank, frame strobe and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_r    <= 4'd0;
      frame_cnt_r <= 4'd0;
      fft_valid_r <= 1'b0;
      for (int i = 0; i < N_POINT; i++) begin
        fill_bank_r[i] <= '0;
        out_bank_r[i]  <= '0;
      end
    end else begin
      fft_valid_r <= 1'b0;
      if (fir_valid) begin
        fill_bank_r[wr_idx_r] <= sample_cplx_s;
        wr_idx_r              <= wr_idx_r + 4'd1;
        // The 16th sample bypasses the fill bank so the frame lands with no extra cycle.
        if (wr_idx_r == LAST_IDX) begin
          for (int i = 0; i < N_POINT - 1; i++) begin
            out_bank_r[i] <= fill_bank_r[i];
          end
          out_bank_r[N_POINT-1] <= sample_cplx_s;
          fft_valid_r           <= 1'b1;
          frame_cnt_r           <= frame_cnt_r + 4'd1;
        end else begin
          fft_valid_r <= 1'b0;
        end
      end else begin
        wr_idx_r <= wr_idx_r;
      end
    end
  end

  assign fft_valid      = fft_valid_r;
  assign frame_cnt      = frame_cnt_r;
  assign fft_data0_out  = out_bank_r[0];
  assign fft_data1_out  = out_bank_r[1];
  assign fft_data2_out  = out_bank_r[2];
  assign fft_data3_out  = out_bank_r[3];
  assign fft_data4_out  = out_bank_r[4];
  assign fft_data5_out  = out_bank_r[5];
  assign fft_data6_out  = out_bank_r[6];
  assign fft_data7_out  = out_bank_r[7];
  assign fft_data8_out  = out_bank_r[8];
  assign fft_data9_out  = out_bank_r[9];
  assign fft_data10_out = out_bank_r[10];
  assign fft_data11_out = out_bank_r[11];
  assign fft_data12_out = out_bank_r[12];
  assign fft_data13_out = out_bank_r[13];
  assign fft_data14_out = out_bank_r[14];
  assign fft_data15_out = out_bank_r[15];

endmodule

// File: tb/tb_fft_s2p_buffer.sv
// Self-checking bench for fft_s2p_buffer: directed and randomized scenarios
// compared against a queue-based frame model plus always-on invariant checks.
module tb_fft_s2p_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fir_valid = 1'b0;
  logic [15:0] fir_d = 16'h0000;
  logic [63:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14, d15;
  logic        fft_valid;
  logic [3:0]  frame_cnt;
  logic [63:0] dout [16];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses [$];

  fft_s2p_buffer #(.IN_W(16), .PAD_LSB(8)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .fft_data0_out(d0), .fft_data1_out(d1), .fft_data2_out(d2), .fft_data3_out(d3),
    .fft_data4_out(d4), .fft_data5_out(d5), .fft_data6_out(d6), .fft_data7_out(d7),
    .fft_data8_out(d8), .fft_data9_out(d9), .fft_data10_out(d10), .fft_data11_out(d11),
    .fft_data12_out(d12), .fft_data13_out(d13), .fft_data14_out(d14), .fft_data15_out(d15),
    .fft_valid(fft_valid), .frame_cnt(frame_cnt)
  );

  assign dout[0] = d0;   assign dout[1] = d1;   assign dout[2] = d2;   assign dout[3] = d3;
  assign dout[4] = d4;   assign dout[5] = d5;   assign dout[6] = d6;   assign dout[7] = d7;
  assign dout[8] = d8;   assign dout[9] = d9;   assign dout[10] = d10; assign dout[11] = d11;
  assign dout[12] = d12; assign dout[13] = d13; assign dout[14] = d14; assign dout[15] = d15;

  always #5 clk = ~clk;

  // Q8.8 value scaled by 2^8 into Q16.16, imag zero.
  function automatic logic [63:0] fmt(input logic [15:0] s);
    logic signed [31:0] r;
    r = 32'(signed'(s)) * 32'sd256;
    return {r, 32'h0000_0000};
  endfunction

  // Reference model: collect accepted samples; every 16 form a frame.
  logic [63:0] fill_q [$];
  logic [63:0] exp_frame [16];
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_cnt = 4'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q.delete();
      exp_valid = 1'b0;
      exp_cnt = 4'd0;
      for (int i = 0; i < 16; i++) exp_frame[i] = 64'h0;
    end else begin
      exp_valid = 1'b0;
      if (fir_valid) begin
        fill_q.push_back(fmt(fir_d));
        if (fill_q.size() == 16) begin
          for (int i = 0; i < 16; i++) exp_frame[i] = fill_q[i];
          fill_q.delete();
          exp_valid = 1'b1;
          exp_cnt = exp_cnt + 4'd1;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  // Continuous model comparison and invariants, sampled on the falling edge.
  logic        prev_valid = 1'b0;
  logic [63:0] prev_out [16];
  initial for (int i = 0; i < 16; i++) prev_out[i] = 64'h0;

  always @(negedge clk) begin
    if (rst !== 1'b0 && rst !== 1'b1) begin
      errors++;
    end else begin
      checks++;
      if (fft_valid !== exp_valid || frame_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL model_ctrl t=%0t valid=%b/%b cnt=%0d/%0d (got/exp)", $time, fft_valid, exp_valid, frame_cnt, exp_cnt);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (dout[i] !== exp_frame[i]) begin
          errors++;
          $display("FAIL model_slot%0d t=%0t got=%h exp=%h", i, $time, dout[i], exp_frame[i]);
        end
      end
      checks++;
      if (fft_valid && prev_valid) begin
        errors++;
        $display("FAIL valid_twice t=%0t got=1,1 exp=not two consecutive", $time);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rst && !fft_valid && dout[i] !== prev_out[i]) begin
          errors++;
          $display("FAIL hold_slot%0d t=%0t got=%h exp=%h", i, $time, dout[i], prev_out[i]);
        end
        prev_out[i] = dout[i];
      end
      prev_valid = fft_valid;
      if (fft_valid) pulses.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input logic [15:0] d);
    @(negedge clk);
    #1;
    fir_valid = v;
    fir_d = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    fir_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (fft_valid !== 1'b0 || frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b cnt=%0d exp valid=0 cnt=0", fft_valid, frame_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout[i] !== 64'h0) begin
        errors++;
        $display("FAIL reset_slot%0d got=%h exp=0", i, dout[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    for (int i = 1; i <= 16; i++) drive(1'b1, 16'(i));
    drive(1'b0, 16'h0);
    checks++;
    if (fft_valid !== 1'b1) begin
      errors++;
      $display("FAIL ramp_valid got=%b exp=1", fft_valid);
    end
    checks++;
    if (d0 !== 64'h00000100_00000000 || d15 !== 64'h00001000_00000000) begin
      errors++;
      $display("FAIL ramp_data got d0=%h d15=%h exp d0=0000010000000000 d15=0000100000000000", d0, d15);
    end
    drive(1'b0, 16'h0);
    checks++;
    if (fft_valid !== 1'b0) begin
      errors++;
      $display("FAIL ramp_pulse_width got=%b exp=0", fft_valid);
    end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 16; i++) drive(1'b1, (i == 3) ? 16'hFF80 : 16'($urandom));
    drive(1'b0, 16'h0);
    checks++;
    if (d3 !== 64'hFFFF8000_00000000) begin
      errors++;
      $display("FAIL negative_slot3 got=%h exp=ffff800000000000", d3);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] smp [16];
    int n0;
    n0 = pulses.size();
    for (int i = 0; i < 16; i++) begin
      smp[i] = 16'($urandom);
      drive(1'b1, smp[i]);
      repeat ($urandom_range(0, 5)) drive(1'b0, 16'($urandom));
    end
    repeat (2) drive(1'b0, 16'($urandom));
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout[i] !== fmt(smp[i])) begin
        errors++;
        $display("FAIL gaps_slot%0d got=%h exp=%h", i, dout[i], fmt(smp[i]));
      end
    end
    checks++;
    if (pulses.size() - n0 != 1) begin
      errors++;
      $display("FAIL gaps_pulses got=%0d exp=1", pulses.size() - n0);
    end
    repeat (10) drive(1'b0, 16'($urandom));
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout[i] !== fmt(smp[i])) begin
        errors++;
        $display("FAIL gaps_hold%0d got=%h exp=%h", i, dout[i], fmt(smp[i]));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] smp [16];
    for (int i = 0; i < 7; i++) drive(1'b1, 16'($urandom));
    @(negedge clk);
    #1;
    fir_valid = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if (fft_valid !== 1'b0 || frame_cnt !== 4'd0 || d0 !== 64'h0 || d15 !== 64'h0) begin
      errors++;
      $display("FAIL midreset_clear got valid=%b cnt=%0d d0=%h d15=%h exp all 0", fft_valid, frame_cnt, d0, d15);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      smp[i] = 16'($urandom);
      drive(1'b1, smp[i]);
    end
    drive(1'b0, 16'h0);
    checks++;
    if (fft_valid !== 1'b1 || frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL midreset_pulse got valid=%b cnt=%0d exp valid=1 cnt=1", fft_valid, frame_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout[i] !== fmt(smp[i])) begin
        errors++;
        $display("FAIL midreset_slot%0d got=%h exp=%h", i, dout[i], fmt(smp[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [48];
    do_reset();
    pulses.delete();
    for (int i = 0; i < 48; i++) begin
      smp[i] = 16'($urandom);
      drive(1'b1, smp[i]);
    end
    repeat (2) drive(1'b0, 16'h0);
    checks++;
    if (pulses.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulse_count got=%0d exp=3", pulses.size());
    end else begin
      checks++;
      if (pulses[1] - pulses[0] != 16 || pulses[2] - pulses[1] != 16) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d exp=16,16", pulses[1] - pulses[0], pulses[2] - pulses[1]);
      end
    end
    checks++;
    if (frame_cnt !== 4'd3) begin
      errors++;
      $display("FAIL b2b_frame_cnt got=%0d exp=3", frame_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout[i] !== fmt(smp[32+i])) begin
        errors++;
        $display("FAIL b2b_slot%0d got=%h exp=%h", i, dout[i], fmt(smp[32+i]));
      end
    end
  endtask

  task automatic test_cnt_wrap();
    for (int f = 0; f < 13; f++) begin
      for (int i = 0; i < 16; i++) drive(1'b1, 16'($urandom));
    end
    drive(1'b0, 16'h0);
    checks++;
    if (frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_wrap got=%0d exp=0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    test_cnt_wrap();
    repeat (3) drive(1'b0, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_s2p_buffer.md
FFT_S2P_BUFFER -- requirements
Module: fft_s2p_buffer

Interface
REQ-001 The module SHALL have parameter IN_W, default 16: input sample width, signed Q8.8.
REQ-002 The module SHALL have parameter PAD_LSB, default 8: number of zero LSBs appended to place a Q8.8 sample into the 32-bit Q16.16 format.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port fir_valid, input, 1 bit: fir_d carries a valid sample this cycle.
REQ-006 The module SHALL have port fir_d, input, IN_W bits: signed time-domain sample.
REQ-007 The module SHALL have ports fft_data0_out to fft_data15_out, outputs, 64 bits each: {real[31:0], imag[31:0]}; these drive stage1_dataN_in directly.
REQ-008 The module SHALL have port fft_valid, output, 1 bit: a one-cycle pulse marking that a new frame is present on fft_dataN_out.
REQ-009 The module SHALL have port frame_cnt, output, 4 bits: number of completed frames, modulo 16.

Function
REQ-010 Each accepted sample SHALL be formatted as real = {{(32-IN_W-PAD_LSB){fir_d[IN_W-1]}}, fir_d, PAD_LSB'b0}, with imag = 32'h0.
REQ-011 A sample SHALL be accepted on every rising clk edge where fir_valid=1; there is no backpressure and no ready signal.
REQ-012 A 4-bit write index wr_idx SHALL select the fill-bank slot for the accepted sample; it increments on each accept and wraps from 15 to 0.
REQ-013 While fir_valid=0, wr_idx and the fill bank SHALL hold their values; input gaps of any length are legal.
REQ-014 On the edge that accepts the sample at wr_idx=15, all 16 output registers SHALL load in one cycle: slots 0-14 from the fill bank and slot 15 directly from the current formatted sample.
REQ-015 fft_valid SHALL be high for exactly the cycle following the edge in REQ-014 (latency 1 cycle from the 16th fir_valid) and low otherwise.
REQ-016 The first sample of a frame SHALL appear on fft_data0_out and the 16th on fft_data15_out, in natural order.
REQ-017 The output registers SHALL hold unchanged until the next frame completes; the FFT stage may sample them at any time between pulses.
REQ-018 When a frame completes and the next sample arrives on the following cycle, that sample SHALL be written to slot 0 with no dropped sample and no bubble, because the fill bank and output bank are separate.
REQ-019 frame_cnt SHALL increment on the same edge that sets fft_valid and wrap from 15 to 0.
REQ-020 The formatting SHALL be a pure sign-extend and shift; there is no saturation, rounding or arithmetic on the data path.

Reset
REQ-021 Asserting rst=0 at any time SHALL immediately clear wr_idx, frame_cnt, fft_valid, the fill bank and all fft_dataN_out to 0.
REQ-022 A partial frame in progress at reset SHALL be discarded; after rst rises, the first accepted sample SHALL go to slot 0.
REQ-023 No fft_valid pulse SHALL occur before 16 samples have been accepted since reset.

Structure
REQ-024 A shared package fft_pkg SHALL hold the constants N_POINT=16, CPLX_W=64, PART_W=32, FRAC_Q=16, and the twiddle constants W0-W7 real/imag, for reuse by all FFT stages.
REQ-025 The block SHALL be a single module with no sub-modules; the fill bank and output bank are plain register arrays, indexed by wr_idx.

Verification
REQ-026 Feed 16 consecutive samples 0x0001..0x0010 with fir_valid=1 -> one cycle after the last sample, fft_valid=1 for one cycle, fft_data0_out=64'h00000100_00000000 and fft_data15_out=64'h00001000_00000000.
REQ-027 Feed a negative sample fir_d=16'hFF80 (-0.5) at slot 3 -> fft_data3_out real = 32'hFFFF8000 and imag = 0.
REQ-028 Feed 16 samples with random fir_valid gaps of 0-5 cycles -> outputs match the ordered samples, fft_valid fires exactly once, and outputs hold until the next frame.
REQ-029 Feed 48 back-to-back samples -> three fft_valid pulses spaced exactly 16 cycles apart, no sample lost, frame_cnt=3.
REQ-030 Assert rst=0 after 7 samples, release it, then feed 16 samples -> all outputs read 0 during reset, and the single pulse afterwards contains only the post-reset samples.
REQ-031 Check invariants: fft_valid is never high on two consecutive cycles, and the outputs never change except on the edge in REQ-014 or on reset.
